pkt_read_engine: RTL and testbench

//  Per-output-port packet reader; counterpart of the datasg write path.

---
 rtl/pkt_read_engine.sv | 142 ++++++++++++++
 tb/tb_pkt_read_engine.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_read_engine.sv
// Per-output-port packet reader: pulls one descriptor, fetches its words from the shared
// SRAM read port under an external grant, and streams them out through a 3-entry buffer.
module pkt_read_engine #(
  parameter int data_width    = 64,
  parameter int address_width = 17,
  parameter int len_width     = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     desc_vld,
  input  logic [address_width-1:0] desc_addr,
  input  logic [len_width-1:0]     desc_len,
  output logic                     desc_rdy,
  output logic                     sram_req,
  output logic [address_width-1:0] sram_addr,
  input  logic                     sram_gnt,
  input  logic [data_width-1:0]    sram_dout,
  input  logic                     ready,
  output logic                     rd_vld,
  output logic                     rd_sop,
  output logic                     rd_eop,
  output logic [data_width-1:0]    rd_data,
  output logic                     busy
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t                   state_q, state_d;
  logic [address_width-1:0] addr_q, addr_d;
  logic [len_width-1:0]     rem_q, rem_d;
  logic                     first_q, first_d;
  logic                     inflight_q, inflight_sop_q, inflight_eop_q;

  logic [data_width-1:0]    buf_data_q [3];
  logic [2:0]               buf_sop_q, buf_eop_q;
  logic [1:0]               wr_ptr_q, rd_ptr_q, count_q;

  logic accept, grant, push, pop;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  assign desc_rdy  = (state_q == IDLE);
  assign accept    = desc_vld && desc_rdy;
  // Room check counts the word already in flight so the buffer can never overflow.
  assign sram_req  = (state_q == FETCH) && (({1'b0, count_q} + {2'b0, inflight_q}) < 3'd3);
  assign sram_addr = addr_q;
  assign grant     = sram_req && sram_gnt;
  assign push      = inflight_q;
  assign rd_vld    = (count_q != 2'd0);
  assign pop       = rd_vld && ready;
  assign rd_data   = buf_data_q[rd_ptr_q];
  assign rd_sop    = rd_vld && buf_sop_q[rd_ptr_q];
  assign rd_eop    = rd_vld && buf_eop_q[rd_ptr_q];
  assign busy      = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    first_d = first_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d  = desc_addr;
          rem_d   = desc_len;
          first_d = 1'b1;
          if (desc_len != '0) state_d = FETCH;
        end
      end
      FETCH: begin
        if (grant) begin
          addr_d  = addr_q + 1'b1;
          rem_d   = rem_q - 1'b1;
          first_d = 1'b0;
          if (rem_q == len_width'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (count_q == 2'd0 && !inflight_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      addr_q         <= '0;
      rem_q          <= '0;
      first_q        <= 1'b0;
      inflight_q     <= 1'b0;
      inflight_sop_q <= 1'b0;
      inflight_eop_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      rem_q          <= rem_d;
      first_q        <= first_d;
      inflight_q     <= grant;
      inflight_sop_q <= first_q;
      inflight_eop_q <= (rem_q == len_width'(1));
    end
  end

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (rst) begin
          buf_data_q[gi] <= '0;
          buf_sop_q[gi]  <= 1'b0;
          buf_eop_q[gi]  <= 1'b0;
        end else if (push && wr_ptr_q == 2'(gi)) begin
          buf_data_q[gi] <= sram_dout;
          buf_sop_q[gi]  <= inflight_sop_q;
          buf_eop_q[gi]  <= inflight_eop_q;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && count_q == 2'd3));

endmodule

// File: tb/tb_pkt_read_engine.sv
// Randomized bench for pkt_read_engine: SRAM model, packet-level reference queues,
// and a negedge monitor checking addresses, data order, flags and handshake rules.
module tb_pkt_read_engine;
  localparam int DW = 64;
  localparam int AW = 17;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          desc_vld = 1'b0;
  logic [AW-1:0] desc_addr = '0;
  logic [LW-1:0] desc_len = '0;
  logic          desc_rdy;
  logic          sram_req;
  logic [AW-1:0] sram_addr;
  logic          sram_gnt = 1'b0;
  logic [DW-1:0] sram_dout = '0;
  logic          ready = 1'b0;
  logic          rd_vld, rd_sop, rd_eop, busy;
  logic [DW-1:0] rd_data;

  pkt_read_engine #(.data_width(DW), .address_width(AW), .len_width(LW)) dut (
    .clk(clk), .rst(rst),
    .desc_vld(desc_vld), .desc_addr(desc_addr), .desc_len(desc_len), .desc_rdy(desc_rdy),
    .sram_req(sram_req), .sram_addr(sram_addr), .sram_gnt(sram_gnt), .sram_dout(sram_dout),
    .ready(ready), .rd_vld(rd_vld), .rd_sop(rd_sop), .rd_eop(rd_eop),
    .rd_data(rd_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] mem_word(input logic [AW-1:0] a);
    return {32'(a) ^ 32'hC0DE_0000, ~32'(a)};
  endfunction

  // Reference model: expected grant addresses and expected output words.
  typedef struct {
    logic [63:0] d;
    logic        sop;
    logic        eop;
  } word_t;
  word_t         exp_q[$];
  logic [AW-1:0] exp_addr_q[$];
  int outstanding = 0;
  int grants = 0;
  int delivered = 0;

  task automatic model_push(input logic [AW-1:0] addr, input int len);
    logic [AW-1:0] a;
    word_t w;
    a = addr;
    for (int i = 0; i < len; i++) begin
      exp_addr_q.push_back(a);
      w.d = mem_word(a);
      w.sop = (i == 0);
      w.eop = (i == len - 1);
      exp_q.push_back(w);
      a = a + 17'd1;
    end
  endtask

  // Grant / ready pattern generators.
  int gnt_mode = 0;  // 0 always, 1 toggle, 2 random
  int rdy_mode = 0;  // 0 always, 1 random, 2 held low
  always @(posedge clk) begin
    #1;
    case (gnt_mode)
      0:       sram_gnt = 1'b1;
      1:       sram_gnt = ~sram_gnt;
      default: sram_gnt = 1'($urandom_range(0, 1));
    endcase
    case (rdy_mode)
      0:       ready = 1'b1;
      1:       ready = 1'($urandom_range(0, 1));
      default: ready = 1'b0;
    endcase
  end

  // SRAM: data valid the cycle after a granted request, garbage otherwise.
  logic          g_s = 1'b0;
  logic [AW-1:0] a_s = '0;
  always @(negedge clk) begin
    g_s = sram_req && sram_gnt;
    a_s = sram_addr;
  end
  always @(posedge clk) begin
    #1;
    sram_dout = g_s ? mem_word(a_s) : {$urandom, $urandom};
  end

  // Monitor
  logic          prev_wait = 1'b0, prev_stall = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  logic [DW-1:0] prev_data = '0;
  logic          prev_sop = 1'b0, prev_eop = 1'b0;
  always @(negedge clk) begin
    word_t w;
    if (rst) begin
      prev_wait  = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (sram_req) check_val("req_room", 64'(outstanding < 3), 64'd1);
      if (prev_wait) begin
        check_val("req_hold", 64'(sram_req), 64'd1);
        check_val("addr_hold", 64'(sram_addr), 64'(prev_addr));
      end
      if (sram_req && sram_gnt) begin
        if (exp_addr_q.size() == 0) check_val("extra_grant", 64'd1, 64'd0);
        else check_val("grant_addr", 64'(sram_addr), 64'(exp_addr_q.pop_front()));
        outstanding++;
        grants++;
      end
      if (prev_stall) begin
        check_val("vld_hold", 64'(rd_vld), 64'd1);
        check_val("data_hold", rd_data, prev_data);
        check_val("flag_hold", {62'd0, rd_sop, rd_eop}, {62'd0, prev_sop, prev_eop});
      end
      if (rd_vld && ready) begin
        if (exp_q.size() == 0) check_val("extra_word", 64'd1, 64'd0);
        else begin
          w = exp_q.pop_front();
          check_val("rd_data", rd_data, w.d);
          check_val("rd_sop", 64'(rd_sop), 64'(w.sop));
          check_val("rd_eop", 64'(rd_eop), 64'(w.eop));
        end
        outstanding--;
        delivered++;
      end
      prev_wait  = sram_req && !sram_gnt;
      prev_addr  = sram_addr;
      prev_stall = rd_vld && !ready;
      prev_data  = rd_data;
      prev_sop   = rd_sop;
      prev_eop   = rd_eop;
    end
  end

  task automatic send_desc(input logic [AW-1:0] a, input int len);
    int n;
    @(posedge clk); #1;
    n = 0;
    while (!desc_rdy && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    check_val("desc_rdy_wait", 64'(desc_rdy), 64'd1);
    desc_vld  = 1'b1;
    desc_addr = a;
    desc_len  = LW'(len);
    @(posedge clk);
    if (len != 0) model_push(a, len);
    $display("desc addr=%05h len=%0d", a, len);
    #1;
    desc_vld = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check_val("idle_timeout", 64'(n < 3000), 64'd1);
    check_val("rdy_after", 64'(desc_rdy), 64'd1);
  endtask

  task automatic check_zero_outputs(input string tag);
    check_val(tag, {rd_data[59:0], rd_vld, rd_sop, rd_eop, busy}, 64'd0);
    check_val({tag, "_req"}, {62'd0, sram_req, desc_rdy}, 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int g0, d0, n;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_zero_outputs("reset");
    check_val("reset_data_hi", rd_data, 64'd0);

    // Basic 4-word packet with exact latency profile.
    gnt_mode = 0; rdy_mode = 0;
    send_desc(17'h00010, 4);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check_val($sformatf("lat_req%0d", k), 64'(sram_req), 64'(k <= 4));
      if (k <= 4) check_val($sformatf("lat_addr%0d", k), 64'(sram_addr), 64'(16 + k - 1));
      check_val($sformatf("lat_vld%0d", k), 64'(rd_vld), 64'(k >= 3 && k <= 6));
      check_val($sformatf("lat_sop%0d", k), 64'(rd_sop), 64'(k == 3));
      check_val($sformatf("lat_eop%0d", k), 64'(rd_eop), 64'(k == 6));
    end
    wait_idle();

    // Single-word packet.
    send_desc(17'h00200, 1);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check_val($sformatf("one_vld%0d", k), 64'(rd_vld), 64'(k == 3));
      if (k == 3) check_val("one_flags", {62'd0, rd_sop, rd_eop}, 64'd3);
    end
    wait_idle();

    // Zero-length descriptor is dropped.
    send_desc(17'h00300, 0);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check_val($sformatf("zero%0d", k), {61'd0, sram_req, rd_vld, busy}, 64'd0);
      check_val($sformatf("zero_rdy%0d", k), 64'(desc_rdy), 64'd1);
    end

    // Address wrap.
    d0 = delivered;
    send_desc(17'h1FFFE, 4);
    wait_idle();
    check_val("wrap_count", 64'(delivered - d0), 64'd4);

    // Backpressure: only three words may be fetched while ready is low.
    rdy_mode = 2;
    g0 = grants; d0 = delivered;
    send_desc(17'h00400, 8);
    repeat (10) @(negedge clk);
    check_val("bp_grants", 64'(grants - g0), 64'd3);
    check_val("bp_req_low", 64'(sram_req), 64'd0);
    check_val("bp_vld", 64'(rd_vld), 64'd1);
    rdy_mode = 0;
    wait_idle();
    check_val("bp_count", 64'(delivered - d0), 64'd8);

    // Random packets under toggling and random grants with random ready.
    for (int p = 0; p < 16; p++) begin
      gnt_mode = (p < 8) ? 1 : 2;
      rdy_mode = 1;
      send_desc(AW'($urandom), $urandom_range(1, 12));
    end
    wait_idle();

    // Reset mid-packet after three words delivered.
    gnt_mode = 1; rdy_mode = 1;
    d0 = delivered;
    send_desc(17'h01234, 8);
    n = 0;
    while ((delivered - d0) < 3 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check_val("rst_mid_reach", 64'(n < 500), 64'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    exp_q.delete();
    exp_addr_q.delete();
    outstanding = 0;
    #1 rst = 1'b0;
    @(negedge clk);
    check_zero_outputs("rst_mid");
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_val($sformatf("post_rst_idle%0d", k), {62'd0, rd_vld, sram_req}, 64'd0);
    end

    // Recovery packet.
    gnt_mode = 0; rdy_mode = 0;
    d0 = delivered;
    send_desc(17'h00050, 5);
    wait_idle();
    check_val("recover_count", 64'(delivered - d0), 64'd5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
